imem_boot_loader: RTL

- Sits upstream of the single-cycle RISC-V core.
- Receives a program as a byte stream using a valid/ready handshake from a UART or debug host.
- Packs the bytes into 32-bit little-endian words and writes them into the instruction memory's write port.
- Holds the core in reset until the full image has loaded and its checksum has verified; releases the core only then.

---
 rtl/imem_boot_loader_pkg.sv | 24 ++
 rtl/imem_boot_loader_if.sv | 21 ++
 rtl/imem_boot_loader_packer.sv | 44 ++++
 rtl/imem_boot_loader.sv | 130 +++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Imported by the loader top and the byte packer.
package boot_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        PAYLOAD,
        CHECK,
        DONE,
        ERROR
    } boot_state_e;

    localparam int HDR_W          = 16;
    localparam int BYTES_PER_WORD = 4;

    function automatic logic [31:0] word_addr(
        input logic [31:0]      base,
        input logic [HDR_W-1:0] idx
    );
        return base + {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream valid/ready handshake feeding the boot loader.
// The host drives the master side; the loader is the slave.
interface imem_boot_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/imem_boot_loader_packer.sv
// Assembles four little-endian stream bytes into one 32-bit word.
// word_valid pulses for one cycle after the fourth byte is taken.
module boot_byte_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  din,
    output logic        last,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q;
    logic [23:0] asm_q;

    assign last = (idx_q == 2'(BYTES_PER_WORD - 1));

    // word is not cleared so the memory write data holds between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            asm_q      <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                idx_q <= '0;
                asm_q <= '0;
            end else if (en) begin
                idx_q <= idx_q + 2'd1;
                asm_q <= {din, asm_q[23:8]};
                if (last) begin
                    word       <= {din, asm_q};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction
// memory and holds the core in reset until the image verifies.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    imem_boot_loader_if.slave src,
    input  logic             reload,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             core_rst_n,
    output logic             done,
    output logic             error,
    output logic [15:0]      words_loaded
);

    boot_state_e      state_q, state_d;
    logic [7:0]       n_lo_q;
    logic [HDR_W-1:0] n_q;
    logic [HDR_W-1:0] n_full;
    logic [7:0]       acc_q;
    logic [HDR_W-1:0] wl_q;
    logic [31:0]      addr_q;
    logic             ready;
    logic             accept;
    logic             pk_last;
    logic             pk_valid;
    logic [31:0]      pk_word;

    assign accept = src.in_valid & ready;
    assign n_full = {src.in_data, n_lo_q};

    boot_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (reload),
        .en         (accept && state_q == PAYLOAD),
        .din        (src.in_data),
        .last       (pk_last),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HDR_LO;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (reload) begin
            state_d = HDR_LO;
        end else if (accept) begin
            unique case (state_q)
                HDR_LO:  state_d = HDR_HI;
                HDR_HI: begin
                    if ({16'b0, n_full} > 32'(IMEM_DEPTH))
                        state_d = ERROR;
                    else if (n_full == '0)
                        state_d = CHECK;
                    else
                        state_d = PAYLOAD;
                end
                PAYLOAD: begin
                    if (pk_last && wl_q == n_q - 16'd1)
                        state_d = CHECK;
                end
                CHECK: begin
                    state_d = (src.in_data == acc_q) ? DONE : ERROR;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        ready      = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        core_rst_n = 1'b0;
        unique case (1'b1)
            state_q == DONE: begin
                done       = 1'b1;
                core_rst_n = 1'b1;
            end
            state_q == ERROR: error = 1'b1;
            default: ready = ~reload;
        endcase
    end

    // the word counter advances on the accepting edge, so it reads
    // the new count during the one-cycle write pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lo_q <= '0;
            n_q    <= '0;
            acc_q  <= '0;
            wl_q   <= '0;
            addr_q <= '0;
        end else if (reload) begin
            n_lo_q <= '0;
            n_q    <= '0;
            acc_q  <= '0;
            wl_q   <= '0;
        end else if (accept) begin
            if (state_q != CHECK)
                acc_q <= acc_q ^ src.in_data;
            if (state_q == HDR_LO)
                n_lo_q <= src.in_data;
            if (state_q == HDR_HI)
                n_q <= n_full;
            if (state_q == PAYLOAD && pk_last) begin
                addr_q <= word_addr(BASE_ADDR, wl_q);
                wl_q   <= wl_q + 16'd1;
            end
        end
    end

    assign src.in_ready  = ready;
    assign imem_we       = pk_valid;
    assign imem_addr     = addr_q;
    assign imem_wdata    = pk_word;
    assign words_loaded  = wl_q;

endmodule
